x_ramb_sp_gen: RTL and testbench

Parametrised single-port block RAM primitive that replaces the fixed 2K x 9 cell.
- Width is 1/2/4 byte lanes, each lane 8 data bits plus 1 parity bit.
- Depth is 2**ADDR_WIDTH words.
- Adds per-lane write enables, an asynchronous active-low reset, and a hardware clear sequencer that fills the array with INIT.
- Sits in the simprims-style library as the behavioural model for generated memories.

---
 rtl/x_ramb_sp_gen.sv | 153 +++++++++++++++
 tb/tb_x_ramb_sp_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/x_ramb_sp_gen.sv
// Parametrised single-port block RAM (1/2/4 byte lanes, 8 data + 1 parity each)
// with per-lane write enables and an INIT clear sweep. Define RAMB_OUTREG_EN for an extra output register.
module x_ramb_sp_gen #(
  parameter int              BYTES      = 1,
  parameter int              ADDR_WIDTH = 11,
  parameter logic [9*BYTES-1:0] INIT    = '0,
  parameter logic [9*BYTES-1:0] SRVAL   = '0,
  parameter string           WRITE_MODE = "WRITE_FIRST"
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  SSR,
  input  logic [BYTES-1:0]      WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [8*BYTES-1:0]    DI,
  input  logic [BYTES-1:0]      DIP,
  input  logic                  CLR,
  output logic [8*BYTES-1:0]    DO,
  output logic [BYTES-1:0]      DOP,
  output logic                  BUSY
);

  localparam int DW    = 8 * BYTES;
  localparam int WW    = 9 * BYTES;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MODE  = (WRITE_MODE == "WRITE_FIRST") ? 0 :
                         (WRITE_MODE == "READ_FIRST")  ? 1 :
                         (WRITE_MODE == "NO_CHANGE")   ? 2 : 3;

  generate
    if (MODE == 3 || !(BYTES == 1 || BYTES == 2 || BYTES == 4)) begin : gBadParam
      $fatal(1, "x_ramb_sp_gen: illegal WRITE_MODE or BYTES parameter");
    end
  endgenerate

  typedef enum logic {SWEEP, READY} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] sweepCnt_q;
  logic [WW-1:0]         latch_q;
  logic [WW-1:0]         latch_d;
  logic [WW-1:0]         mem [DEPTH];

  logic          portAcc;
  logic          addrKnown;
  logic          doWrite;
  logic [WW-1:0] oldWord;
  logic [WW-1:0] mergedWord;
  logic [WW-1:0] outWord;

  function automatic logic [WW-1:0] mergeLanes(input logic [WW-1:0]    oldW,
                                               input logic [WW-1:0]    newW,
                                               input logic [BYTES-1:0] laneWe);
    logic [WW-1:0] w;
    w = oldW;
    for (int i = 0; i < BYTES; i++) begin
      if (laneWe[i]) begin
        w[8*i +: 8] = newW[8*i +: 8];
        w[DW+i]     = newW[DW+i];
      end
    end
    return w;
  endfunction

  // A CLR request in READY swallows the port access of that same cycle.
  assign portAcc    = (state_q == READY) && EN && !CLR;
  assign addrKnown  = !$isunknown(ADDR);
  assign oldWord    = mem[ADDR];
  assign mergedWord = mergeLanes(oldWord, {DIP, DI}, WE);
  assign doWrite    = portAcc && addrKnown && (WE != '0);

  always_comb begin
    latch_d = latch_q;
    if (portAcc) begin
      if (!addrKnown) begin
        latch_d = 'x;
`ifndef RAMB_OUTREG_EN
      end else if (SSR) begin
        latch_d = SRVAL;
`endif
      end else if (WE == '0) begin
        latch_d = oldWord;
      end else if (MODE == 0) begin
        latch_d = mergedWord;
      end else if (MODE == 1) begin
        latch_d = oldWord;
      end
    end
  end

  // The array has no reset; gating on RST_N keeps reset from disturbing it.
  always_ff @(posedge CLK) begin
    if (state_q == SWEEP && RST_N) begin
      mem[sweepCnt_q] <= INIT;
    end else if (doWrite) begin
      mem[ADDR] <= mergedWord;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= SWEEP;
      busy_q     <= 1'b1;
      sweepCnt_q <= '0;
      latch_q    <= INIT;
    end else begin
      latch_q <= latch_d;
      case (state_q)
        SWEEP: begin
          sweepCnt_q <= sweepCnt_q + 1'b1;
          if (&sweepCnt_q) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          if (CLR) begin
            state_q    <= SWEEP;
            busy_q     <= 1'b1;
            sweepCnt_q <= '0;
          end
        end
        default: begin
          state_q <= SWEEP;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef RAMB_OUTREG_EN
  logic [WW-1:0] pipe_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_q <= INIT;
    end else if (state_q == READY) begin
      pipe_q <= (portAcc && SSR) ? SRVAL : latch_q;
    end
  end

  assign outWord = pipe_q;
`else
  assign outWord = latch_q;
`endif

  assign DO   = outWord[DW-1:0];
  assign DOP  = outWord[WW-1:DW];
  assign BUSY = busy_q;

endmodule

// File: tb/tb_x_ramb_sp_gen.sv
// Directed bench for x_ramb_sp_gen: three instances (one per write mode) share
// the same stimulus, so each vector carries an expected output for every mode.
module tb_x_ramb_sp_gen;

  logic        clk;
  logic        rstN;
  logic        en;
  logic        ssr;
  logic [1:0]  we;
  logic [3:0]  addr;
  logic [15:0] di;
  logic [1:0]  dip;
  logic        clr;

  logic [15:0] doWf, doRf, doNc;
  logic [1:0]  dopWf, dopRf, dopNc;
  logic        busyWf, busyRf, busyNc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        ssr;
    logic [1:0]  we;
    logic [3:0]  addr;
    logic [15:0] di;
    logic [1:0]  dip;
    logic [15:0] expWf;
    logic [1:0]  expWfP;
    logic [15:0] expRf;
    logic [1:0]  expRfP;
    logic [15:0] expNc;
    logic [1:0]  expNcP;
  } vec_t;

  vec_t vecs[16];

  x_ramb_sp_gen #(.BYTES(2), .ADDR_WIDTH(4), .INIT(18'h3_A55A), .SRVAL(18'h0_1234),
                  .WRITE_MODE("WRITE_FIRST")) uWf (
    .CLK(clk), .RST_N(rstN), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .DIP(dip), .CLR(clr), .DO(doWf), .DOP(dopWf), .BUSY(busyWf));

  x_ramb_sp_gen #(.BYTES(2), .ADDR_WIDTH(4), .INIT(18'h3_A55A), .SRVAL(18'h0_1234),
                  .WRITE_MODE("READ_FIRST")) uRf (
    .CLK(clk), .RST_N(rstN), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .DIP(dip), .CLR(clr), .DO(doRf), .DOP(dopRf), .BUSY(busyRf));

  x_ramb_sp_gen #(.BYTES(2), .ADDR_WIDTH(4), .INIT(18'h3_A55A), .SRVAL(18'h0_1234),
                  .WRITE_MODE("NO_CHANGE")) uNc (
    .CLK(clk), .RST_N(rstN), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .DIP(dip), .CLR(clr), .DO(doNc), .DOP(dopNc), .BUSY(busyNc));

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic e, logic s, logic [1:0] w, logic [3:0] a,
                                 logic [15:0] d, logic [1:0] dp,
                                 logic [15:0] wf, logic [1:0] wfp,
                                 logic [15:0] rf, logic [1:0] rfp,
                                 logic [15:0] nc, logic [1:0] ncp);
    vec_t v;
    v.en = e; v.ssr = s; v.we = w; v.addr = a; v.di = d; v.dip = dp;
    v.expWf = wf; v.expWfP = wfp; v.expRf = rf; v.expRfP = rfp;
    v.expNc = nc; v.expNcP = ncp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] expDo, input logic [1:0] expDop);
    checkOutput({tag, " WF DO"}, 32'(doWf), 32'(expDo));
    checkOutput({tag, " WF DOP"}, 32'(dopWf), 32'(expDop));
    checkOutput({tag, " RF DO"}, 32'(doRf), 32'(expDo));
    checkOutput({tag, " RF DOP"}, 32'(dopRf), 32'(expDop));
    checkOutput({tag, " NC DO"}, 32'(doNc), 32'(expDo));
    checkOutput({tag, " NC DOP"}, 32'(dopNc), 32'(expDop));
  endtask

  task automatic checkBusy(input string tag, input logic expBusy);
    checkOutput({tag, " WF BUSY"}, 32'(busyWf), 32'(expBusy));
    checkOutput({tag, " RF BUSY"}, 32'(busyRf), 32'(expBusy));
    checkOutput({tag, " NC BUSY"}, 32'(busyNc), 32'(expBusy));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    en = v.en; ssr = v.ssr; we = v.we; addr = v.addr; di = v.di; dip = v.dip; clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " WF DO"}, 32'(doWf), 32'(v.expWf));
    checkOutput({tag, " WF DOP"}, 32'(dopWf), 32'(v.expWfP));
    checkOutput({tag, " RF DO"}, 32'(doRf), 32'(v.expRf));
    checkOutput({tag, " RF DOP"}, 32'(dopRf), 32'(v.expRfP));
    checkOutput({tag, " NC DO"}, 32'(doNc), 32'(v.expNc));
    checkOutput({tag, " NC DOP"}, 32'(dopNc), 32'(v.expNcP));
    checkBusy(tag, 1'b0);
  endtask

  // Counts cycles with BUSY high, starting at the current (negedge) instant.
  task automatic measureSweep(output int n);
    n = 0;
    while (busyWf === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readAllInit(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en = 1'b1; ssr = 1'b0; we = 2'b00; addr = 4'(i); clr = 1'b0;
      @(posedge clk);
      #1;
      checkAll($sformatf("%s rd%0d", tag, i), 16'hA55A, 2'b11);
    end
  endtask

  initial begin
    int n;
    rstN = 1'b1; en = 1'b0; ssr = 1'b0; we = 2'b00; addr = 4'd0;
    di = 16'h0; dip = 2'b00; clr = 1'b0;

    // Expected values assume INIT=3_A55A, SRVAL=0_1234 and merges by lane.
    vecs[0]  = mkVec(1, 0, 2'b00, 4'd0,  16'h0000, 2'b00, 16'hA55A, 2'b11, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[1]  = mkVec(1, 0, 2'b01, 4'd5,  16'hBEEF, 2'b00, 16'hA5EF, 2'b10, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[2]  = mkVec(1, 0, 2'b00, 4'd5,  16'h0000, 2'b00, 16'hA5EF, 2'b10, 16'hA5EF, 2'b10, 16'hA5EF, 2'b10);
    vecs[3]  = mkVec(1, 0, 2'b11, 4'd3,  16'h1111, 2'b01, 16'h1111, 2'b01, 16'hA55A, 2'b11, 16'hA5EF, 2'b10);
    vecs[4]  = mkVec(1, 0, 2'b00, 4'd3,  16'h0000, 2'b00, 16'h1111, 2'b01, 16'h1111, 2'b01, 16'h1111, 2'b01);
    vecs[5]  = mkVec(1, 0, 2'b00, 4'd0,  16'h0000, 2'b00, 16'hA55A, 2'b11, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[6]  = mkVec(1, 0, 2'b11, 4'd0,  16'h0F0F, 2'b10, 16'h0F0F, 2'b10, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[7]  = mkVec(1, 0, 2'b00, 4'd0,  16'h0000, 2'b00, 16'h0F0F, 2'b10, 16'h0F0F, 2'b10, 16'h0F0F, 2'b10);
    vecs[8]  = mkVec(1, 1, 2'b11, 4'd9,  16'h7777, 2'b11, 16'h1234, 2'b00, 16'h1234, 2'b00, 16'h1234, 2'b00);
    vecs[9]  = mkVec(1, 0, 2'b00, 4'd9,  16'h0000, 2'b00, 16'h7777, 2'b11, 16'h7777, 2'b11, 16'h7777, 2'b11);
    vecs[10] = mkVec(0, 0, 2'b11, 4'd5,  16'hFFFF, 2'b11, 16'h7777, 2'b11, 16'h7777, 2'b11, 16'h7777, 2'b11);
    vecs[11] = mkVec(1, 0, 2'b00, 4'd5,  16'h0000, 2'b00, 16'hA5EF, 2'b10, 16'hA5EF, 2'b10, 16'hA5EF, 2'b10);
    vecs[12] = mkVec(1, 1, 2'b00, 4'd2,  16'h0000, 2'b00, 16'h1234, 2'b00, 16'h1234, 2'b00, 16'h1234, 2'b00);
    vecs[13] = mkVec(1, 0, 2'b00, 4'd15, 16'h0000, 2'b00, 16'hA55A, 2'b11, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[14] = mkVec(1, 0, 2'b10, 4'd15, 16'hCD00, 2'b10, 16'hCD5A, 2'b11, 16'hA55A, 2'b11, 16'hA55A, 2'b11);
    vecs[15] = mkVec(1, 0, 2'b00, 4'd15, 16'h0000, 2'b00, 16'hCD5A, 2'b11, 16'hCD5A, 2'b11, 16'hCD5A, 2'b11);

    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkAll("reset", 16'hA55A, 2'b11);
    checkBusy("reset", 1'b1);

    @(negedge clk);
    rstN = 1'b1;
    measureSweep(n);
    checkOutput("initial sweep length", 32'(n), 32'd16);
    checkBusy("after sweep", 1'b0);
    readAllInit("init");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], i);
    end

    // CLR together with a write: write is dropped, sweep starts, outputs hold.
    @(negedge clk);
    en = 1'b1; ssr = 1'b0; we = 2'b11; addr = 4'd1; di = 16'h0000; dip = 2'b00; clr = 1'b1;
    @(posedge clk);
    #1;
    checkBusy("clr edge", 1'b1);
    checkAll("clr edge", 16'hCD5A, 2'b11);

    // Port activity during the sweep must not move the outputs.
    @(negedge clk);
    clr = 1'b0; en = 1'b1; ssr = 1'b1; we = 2'b11; addr = 4'd0; di = 16'hFFFF;
    for (int c = 1; c < 7; c++) begin
      @(posedge clk);
      #1;
      checkBusy($sformatf("sweep c%0d", c), 1'b1);
      checkAll($sformatf("sweep c%0d", c), 16'hCD5A, 2'b11);
    end

    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkAll("midsweep reset", 16'hA55A, 2'b11);
    checkBusy("midsweep reset", 1'b1);
    repeat (2) @(negedge clk);
    checkBusy("held reset", 1'b1);
    en = 1'b0; ssr = 1'b0; we = 2'b00;
    rstN = 1'b1;
    measureSweep(n);
    checkOutput("restart sweep length", 32'(n), 32'd16);
    checkBusy("after restart", 1'b0);
    readAllInit("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
